// File: rtl/operand_fetch_pkg.sv
// Shared encodings for the operand fetch unit: operand source codes and FSM states.
package operand_fetch_pkg;

    localparam logic [2:0] SRC_IMM   = 3'd0;
    localparam logic [2:0] SRC_CNT   = 3'd1;
    localparam logic [2:0] SRC_INPUT = 3'd2;
    localparam logic [2:0] SRC_RAM   = 3'd3;
    localparam logic [2:0] SRC_STACK = 3'd4;
    localparam logic [2:0] SRC_ZERO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP1  = 2'd1,
        ST_OP2  = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/operand_source_mux.sv
// Single-cycle operand source pick. Multi-cycle sources (INPUT, RAM) report
// direct_o = 0 and are resolved by the fetch FSM.
module operand_source_mux
    import operand_fetch_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       sel_i,
    input  logic [WIDTH-1:0] imm_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] stack_i,
    output logic [WIDTH-1:0] data_o,
    output logic             direct_o
);

    always_comb begin
        data_o   = '0;
        direct_o = 1'b1;
        case (sel_i)
            SRC_IMM:   data_o = imm_i;
            SRC_CNT:   data_o = cnt_i;
            SRC_STACK: data_o = stack_i;
            SRC_INPUT,
            SRC_RAM:   direct_o = 1'b0;
            default:   data_o = '0;
        endcase
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// Sequential operand fetch: latches one decoded instruction, gathers two operands
// over variable-latency sources, presents them to the ALU, and issues the next PC.
module operand_fetch_unit
    import operand_fetch_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        src1_sel,
    input  logic [2:0]        src2_sel,
    input  logic [WIDTH-1:0]  imm1,
    input  logic [WIDTH-1:0]  imm2,
    input  logic [ADDR_W-1:0] mem_addr1,
    input  logic [ADDR_W-1:0] mem_addr2,
    input  logic [WIDTH-1:0]  cnt_value,
    input  logic [WIDTH-1:0]  stack_top,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ack,
    output logic              ram_req,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WIDTH-1:0]  ram_rd_data,
    input  logic              ram_rd_valid,
    input  logic              cnt_wr_en,
    input  logic [WIDTH-1:0]  cnt_wr_addr,
    input  logic              condition,
    input  logic              is_ret,
    input  logic [WIDTH-1:0]  jump_target,
    output logic [WIDTH-1:0]  arg1,
    output logic [WIDTH-1:0]  arg2,
    output logic              args_valid,
    input  logic              args_ready,
    output logic              pc_load,
    output logic [WIDTH-1:0]  pc_next
);

    fetch_state_e      state_q, state_d;
    logic [2:0]        src1_q, src2_q;
    logic [WIDTH-1:0]  imm1_q, imm2_q, cnt_q, stack_q;
    logic [ADDR_W-1:0] addr2_q;
    logic              cwen_q, cond_q, ret_q;
    logic [WIDTH-1:0]  cwaddr_q, target_q;
    logic [WIDTH-1:0]  arg1_q, arg2_q, pc_next_q;
    logic              pc_load_q, ram_req_q;
    logic [ADDR_W-1:0] ram_addr_q;

    logic [2:0]        cur_sel;
    logic [WIDTH-1:0]  cur_imm, mux_data, op_data;
    logic              mux_direct, op_done, accept, handshake;

    operand_source_mux #(.WIDTH(WIDTH)) u_mux (
        .sel_i    (cur_sel),
        .imm_i    (cur_imm),
        .cnt_i    (cnt_q),
        .stack_i  (stack_q),
        .data_o   (mux_data),
        .direct_o (mux_direct)
    );

    assign accept     = (state_q == ST_IDLE) && instr_valid;
    assign handshake  = (state_q == ST_DONE) && args_ready;
    assign instr_ready = (state_q == ST_IDLE);
    assign args_valid  = (state_q == ST_DONE);
    assign arg1        = arg1_q;
    assign arg2        = arg2_q;
    assign pc_load     = pc_load_q;
    assign pc_next     = pc_next_q;
    assign ram_req     = ram_req_q;
    assign ram_addr    = ram_addr_q;

    always_comb begin
        state_d = state_q;
        cur_sel = src1_q;
        cur_imm = imm1_q;
        op_data = mux_data;
        op_done = 1'b0;
        in_ack  = 1'b0;
        if (state_q == ST_OP2) begin
            cur_sel = src2_q;
            cur_imm = imm2_q;
        end
        case (state_q)
            ST_IDLE: if (instr_valid) state_d = ST_OP1;
            ST_OP1, ST_OP2: begin
                if (mux_direct) begin
                    op_done = 1'b1;
                end else if (cur_sel == SRC_INPUT) begin
                    in_ack  = in_valid;
                    op_done = in_valid;
                    op_data = in_data;
                end else begin
                    // data arriving alongside the request belongs to nobody
                    op_done = ram_rd_valid && !ram_req_q;
                    op_data = ram_rd_data;
                end
                if (op_done) state_d = (state_q == ST_OP1) ? ST_OP2 : ST_DONE;
            end
            ST_DONE: if (args_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            src1_q     <= '0;
            src2_q     <= '0;
            imm1_q     <= '0;
            imm2_q     <= '0;
            cnt_q      <= '0;
            stack_q    <= '0;
            addr2_q    <= '0;
            cwen_q     <= 1'b0;
            cond_q     <= 1'b0;
            ret_q      <= 1'b0;
            cwaddr_q   <= '0;
            target_q   <= '0;
            arg1_q     <= '0;
            arg2_q     <= '0;
            pc_next_q  <= '0;
            pc_load_q  <= 1'b0;
            ram_req_q  <= 1'b0;
            ram_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            ram_req_q <= 1'b0;
            pc_load_q <= 1'b0;
            if (accept) begin
                src1_q   <= src1_sel;
                src2_q   <= src2_sel;
                imm1_q   <= imm1;
                imm2_q   <= imm2;
                cnt_q    <= cnt_value;
                stack_q  <= stack_top;
                addr2_q  <= mem_addr2;
                cwen_q   <= cnt_wr_en;
                cond_q   <= condition;
                ret_q    <= is_ret;
                cwaddr_q <= cnt_wr_addr;
                target_q <= jump_target;
                if (src1_sel == SRC_RAM) begin
                    ram_req_q  <= 1'b1;
                    ram_addr_q <= mem_addr1;
                end
            end
            if (state_q == ST_OP1 && op_done) begin
                arg1_q <= op_data;
                // second RAM request only goes out once the first has returned
                if (src2_q == SRC_RAM) begin
                    ram_req_q  <= 1'b1;
                    ram_addr_q <= addr2_q;
                end
            end
            if (state_q == ST_OP2 && op_done) arg2_q <= op_data;
            if (handshake) begin
                if (cwen_q) begin
                    pc_load_q <= 1'b1;
                    pc_next_q <= cwaddr_q;
                end else if (cond_q) begin
                    pc_load_q <= 1'b1;
                    pc_next_q <= ret_q ? stack_q : target_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit: inputs change on the falling edge,
// outputs are checked 1ns later, cycle by cycle against hand-derived values.
module tb_operand_fetch_unit;
    import operand_fetch_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0, instr_ready;
    logic [2:0] src1_sel = '0, src2_sel = '0;
    logic [7:0] imm1 = '0, imm2 = '0, mem_addr1 = '0, mem_addr2 = '0;
    logic [7:0] cnt_value = '0, stack_top = '0, in_data = '0;
    logic       in_valid = 1'b0, in_ack, ram_req;
    logic [7:0] ram_addr, ram_rd_data = '0;
    logic       ram_rd_valid = 1'b0, cnt_wr_en = 1'b0;
    logic [7:0] cnt_wr_addr = '0;
    logic       condition = 1'b0, is_ret = 1'b0;
    logic [7:0] jump_target = '0, arg1, arg2, pc_next;
    logic       args_valid, args_ready = 1'b1, pc_load;

    int checks = 0, failures = 0;
    int req_cnt = 0, ack_cnt = 0, pcl_cnt = 0, ovl_cnt = 0, base;
    logic outst = 1'b0;

    operand_fetch_unit #(.WIDTH(8), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .src1_sel(src1_sel), .src2_sel(src2_sel), .imm1(imm1), .imm2(imm2),
        .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .cnt_value(cnt_value),
        .stack_top(stack_top), .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
        .ram_req(ram_req), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
        .ram_rd_valid(ram_rd_valid), .cnt_wr_en(cnt_wr_en), .cnt_wr_addr(cnt_wr_addr),
        .condition(condition), .is_ret(is_ret), .jump_target(jump_target),
        .arg1(arg1), .arg2(arg2), .args_valid(args_valid), .args_ready(args_ready),
        .pc_load(pc_load), .pc_next(pc_next)
    );

    always #5 clk = ~clk;

    // pulse counters and a one-outstanding-request tracker
    always @(posedge clk) begin
        if (!rst_n) begin
            outst <= 1'b0;
        end else begin
            if (ram_req) req_cnt <= req_cnt + 1;
            if (in_ack)  ack_cnt <= ack_cnt + 1;
            if (pc_load) pcl_cnt <= pcl_cnt + 1;
            if (ram_req) begin
                if (outst) ovl_cnt <= ovl_cnt + 1;
                outst <= 1'b1;
            end else if (ram_rd_valid && outst) begin
                outst <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [2:0] s1, input logic [2:0] s2,
                         input logic [7:0] i1, input logic [7:0] i2,
                         input logic [7:0] a1, input logic [7:0] a2,
                         input logic [7:0] stk, input logic [7:0] cnt);
        instr_valid = 1'b1;
        src1_sel = s1;  src2_sel = s2;
        imm1 = i1;      imm2 = i2;
        mem_addr1 = a1; mem_addr2 = a2;
        stack_top = stk; cnt_value = cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        settle();
        chk("rst_args_valid", args_valid, 0);
        chk("rst_arg1", arg1, 0);
        chk("rst_arg2", arg2, 0);
        chk("rst_pc_next", pc_next, 0);
        chk("rst_pc_load", pc_load, 0);
        chk("rst_ram_req", ram_req, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_in_ack", in_ack, 0);
        chk("rst_instr_ready", instr_ready, 1);
        cyc(); rst_n = 1'b1;

        // all immediates, minimum latency
        base = pcl_cnt;
        cyc(); issue(SRC_IMM, SRC_IMM, 8'h12, 8'h34, 0, 0, 0, 0); settle();
        chk("t1_ready_c0", instr_ready, 1);
        cyc(); instr_valid = 0; settle();
        chk("t1_valid_c1", args_valid, 0);
        chk("t1_ready_c1", instr_ready, 0);
        cyc(); settle();
        chk("t1_valid_c2", args_valid, 0);
        cyc(); settle();
        chk("t1_valid_c3", args_valid, 1);
        chk("t1_arg1", arg1, 8'h12);
        chk("t1_arg2", arg2, 8'h34);
        cyc(); settle();
        chk("t1_ready_c4", instr_ready, 1);
        chk("t1_valid_c4", args_valid, 0);
        chk("t1_no_pc_load", pcl_cnt - base, 0);

        // RAM operand, latency 3, data in the request cycle must be ignored
        base = req_cnt;
        cyc(); issue(SRC_RAM, SRC_IMM, 0, 8'h55, 8'h40, 0, 0, 0); settle();
        cyc(); instr_valid = 0; ram_rd_valid = 1; ram_rd_data = 8'hEE; settle();
        chk("t2_req_c1", ram_req, 1);
        chk("t2_addr_c1", ram_addr, 8'h40);
        cyc(); ram_rd_valid = 0; settle();
        chk("t2_req_c2", ram_req, 0);
        chk("t2_valid_c2", args_valid, 0);
        cyc(); settle();
        cyc(); ram_rd_valid = 1; ram_rd_data = 8'hA5; settle();
        chk("t2_valid_c4", args_valid, 0);
        cyc(); ram_rd_valid = 0; settle();
        chk("t2_valid_c5", args_valid, 0);
        cyc(); settle();
        chk("t2_valid_c6", args_valid, 1);
        chk("t2_arg1", arg1, 8'hA5);
        chk("t2_arg2", arg2, 8'h55);
        chk("t2_req_pulses", req_cnt - base, 1);
        cyc(); settle();

        // both operands from RAM, serialised
        base = req_cnt;
        cyc(); issue(SRC_RAM, SRC_RAM, 0, 0, 8'h10, 8'h20, 0, 0); settle();
        cyc(); instr_valid = 0; settle();
        chk("t2b_req1", ram_req, 1);
        chk("t2b_addr1", ram_addr, 8'h10);
        cyc(); ram_rd_valid = 1; ram_rd_data = 8'h11; settle();
        chk("t2b_req_c2", ram_req, 0);
        cyc(); ram_rd_valid = 0; settle();
        chk("t2b_req2", ram_req, 1);
        chk("t2b_addr2", ram_addr, 8'h20);
        cyc(); ram_rd_valid = 1; ram_rd_data = 8'h22; settle();
        cyc(); ram_rd_valid = 0; settle();
        chk("t2b_valid", args_valid, 1);
        chk("t2b_arg1", arg1, 8'h11);
        chk("t2b_arg2", arg2, 8'h22);
        chk("t2b_req_pulses", req_cnt - base, 2);
        chk("t2b_overlap", ovl_cnt, 0);
        cyc(); settle();

        // two INPUT beats with a gap
        base = ack_cnt;
        cyc(); issue(SRC_INPUT, SRC_INPUT, 0, 0, 0, 0, 0, 0); settle();
        cyc(); instr_valid = 0; settle();
        chk("t3_ack_c1", in_ack, 0);
        cyc(); in_valid = 1; in_data = 8'h07; settle();
        chk("t3_ack_c2", in_ack, 1);
        cyc(); in_valid = 0; settle();
        chk("t3_ack_c3", in_ack, 0);
        cyc(); settle();
        cyc(); settle();
        cyc(); in_valid = 1; in_data = 8'h09; settle();
        chk("t3_ack_c6", in_ack, 1);
        cyc(); in_valid = 0; settle();
        chk("t3_valid", args_valid, 1);
        chk("t3_arg1", arg1, 8'h07);
        chk("t3_arg2", arg2, 8'h09);
        chk("t3_ack_pulses", ack_cnt - base, 2);
        cyc(); settle();

        // return from latched stack_top
        base = pcl_cnt;
        condition = 1; is_ret = 1; jump_target = 8'h99;
        cyc(); issue(SRC_IMM, SRC_CNT, 8'h01, 0, 0, 0, 8'h5C, 8'h3C); settle();
        cyc(); instr_valid = 0; stack_top = 8'h00; cnt_value = 8'h00; settle();
        cyc(); settle();
        cyc(); settle();
        chk("t5_arg2_cnt", arg2, 8'h3C);
        cyc(); settle();
        chk("t5_pc_load", pc_load, 1);
        chk("t5_pc_next", pc_next, 8'h5C);
        chk("t5_ready", instr_ready, 1);
        condition = 0; is_ret = 0;
        cyc(); settle();
        chk("t5_pc_load_drop", pc_load, 0);
        chk("t5_pc_hold", pc_next, 8'h5C);
        chk("t5_pc_pulses", pcl_cnt - base, 1);

        // counter write wins over return
        cnt_wr_en = 1; cnt_wr_addr = 8'h20; condition = 1; is_ret = 1;
        cyc(); issue(SRC_IMM, SRC_IMM, 0, 0, 0, 0, 8'h5C, 0); settle();
        cyc(); instr_valid = 0; settle();
        cyc(); settle();
        cyc(); settle();
        cyc(); settle();
        chk("t5b_pc_load", pc_load, 1);
        chk("t5b_pc_next", pc_next, 8'h20);
        cnt_wr_en = 0; condition = 0; is_ret = 0;

        // back-pressure, then a pending instruction (ZERO source, jump)
        args_ready = 0;
        cyc(); issue(SRC_IMM, SRC_STACK, 8'hA1, 0, 0, 0, 8'hB2, 0); settle();
        cyc(); instr_valid = 0; stack_top = 8'h00; settle();
        cyc(); settle();
        for (int c = 3; c <= 7; c++) begin
            cyc();
            if (c == 4) begin
                issue(SRC_IMM, 3'd7, 8'hFF, 8'h66, 0, 0, 0, 0);
                condition = 1; jump_target = 8'h77;
            end
            settle();
            chk("t4_valid_hold", args_valid, 1);
            chk("t4_arg1_hold", arg1, 8'hA1);
            chk("t4_arg2_hold", arg2, 8'hB2);
            chk("t4_ready_low", instr_ready, 0);
        end
        cyc(); args_ready = 1; settle();
        chk("t4_valid_c8", args_valid, 1);
        cyc(); settle();
        chk("t4_ready_c9", instr_ready, 1);
        chk("t4_no_pc_load", pc_load, 0);
        chk("t4_pc_hold", pc_next, 8'h20);
        cyc(); instr_valid = 0; settle();
        chk("t4_accepted", instr_ready, 0);
        cyc(); settle();
        cyc(); settle();
        chk("t4b_valid", args_valid, 1);
        chk("t4b_arg1", arg1, 8'hFF);
        chk("t4b_arg2_zero", arg2, 8'h00);
        cyc(); settle();
        chk("t4b_pc_load", pc_load, 1);
        chk("t4b_pc_next", pc_next, 8'h77);
        condition = 0;

        // reset while waiting on RAM
        cyc(); issue(SRC_RAM, SRC_IMM, 0, 8'h44, 8'h33, 0, 0, 0); settle();
        cyc(); instr_valid = 0; settle();
        chk("t6_req", ram_req, 1);
        cyc(); settle();
        rst_n = 0; settle();
        chk("t6_rst_valid", args_valid, 0);
        chk("t6_rst_req", ram_req, 0);
        chk("t6_rst_addr", ram_addr, 0);
        chk("t6_rst_arg1", arg1, 0);
        chk("t6_rst_pc_next", pc_next, 0);
        chk("t6_rst_pc_load", pc_load, 0);
        chk("t6_rst_ready", instr_ready, 1);
        cyc(); rst_n = 1; ram_rd_valid = 1; ram_rd_data = 8'hDD; settle();
        chk("t6_idle_ready", instr_ready, 1);
        cyc(); ram_rd_valid = 0; settle();
        chk("t6_late_valid", args_valid, 0);
        chk("t6_late_arg1", arg1, 0);
        chk("t6_late_ready", instr_ready, 1);
        chk("t6_late_req", ram_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
